// File: rtl/maze_pkg.sv
// ----------------------------------------------------------------------------
// maze_pkg
// Shared maze definitions used by the movement logic and the ROM arbiter.
//   MAZE_COLS / MAZE_ROWS : maze geometry (ROM row width / populated rows)
//   tile_x_t / tile_y_t   : tile coordinate types
//   REQ_*                 : requester indices on the shared maze ROM
//   col_bit()             : extract the wall bit for column x from a ROM row
// ----------------------------------------------------------------------------
package maze_pkg;

    localparam int MAZE_COLS  = 32;
    localparam int MAZE_ROWS  = 24;
    localparam int NUM_MOVERS = 5;

    typedef logic [4:0] tile_x_t;
    typedef logic [4:0] tile_y_t;

    localparam int REQ_PAC    = 0;
    localparam int REQ_GHOST0 = 1;
    localparam int REQ_GHOST1 = 2;
    localparam int REQ_GHOST2 = 3;
    localparam int REQ_GHOST3 = 4;

    // Column 0 lives in the MSB of a ROM row; shifting left by x brings
    // column x into the MSB position.
    function automatic logic col_bit(input logic [MAZE_COLS-1:0] row,
                                     input tile_x_t              x);
        logic [MAZE_COLS-1:0] shifted;
        shifted = row << x;
        return shifted[MAZE_COLS-1];
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin arbiter. Grants the first requester at or after
// ptr, scanning upward and wrapping to index 0. The pointer is owned by the
// caller so it can decide when a grant is actually consumed.
//   req : request vector
//   ptr : highest-priority index this cycle
//   gnt : one-hot grant, all-zero when req is all-zero
// ----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int N     = 5,
    parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     gnt
);

    logic [N-1:0] hi_mask;
    logic [N-1:0] req_hi;
    logic [N-1:0] first_hi;
    logic [N-1:0] first_any;

    // Bits at or above ptr. A ptr beyond N-1 yields an empty mask, which
    // simply falls back to plain lowest-index priority.
    assign hi_mask   = ~((N'(1) << ptr) - N'(1));
    assign req_hi    = req & hi_mask;

    // x & -x isolates the lowest set bit.
    assign first_hi  = req_hi & (~req_hi + N'(1));
    assign first_any = req & (~req + N'(1));

    // Nothing at or above ptr means the scan wraps to the lowest index.
    assign gnt = (|req_hi) ? first_hi : first_any;

endmodule

// File: rtl/maze_rom_arbiter.sv
// ----------------------------------------------------------------------------
// maze_rom_arbiter
// Shares the single-port maze ROM between Pac-Man (requester 0) and the four
// ghosts. One lookup may be accepted per cycle; each answers "is tile (x,y)
// blocked" two clocks after acceptance, on a one-hot strobe to the asker.
//   clk, reset    : clock, synchronous active-high reset
//   req_valid     : per-requester lookup request
//   req_x, req_y  : packed tile coordinates, slice i belongs to requester i
//   req_ready     : one-hot grant; accept = req_valid[i] & req_ready[i]
//   rom_addr      : ROM row address, registered at the accept edge
//   rom_data      : ROM row, registered by the ROM one clock after rom_addr
//   resp_valid    : one-hot, one-cycle response strobe
//   resp_blocked  : 1 = wall or off-maze, valid only with resp_valid
// ----------------------------------------------------------------------------
module maze_rom_arbiter
    import maze_pkg::*;
#(
    parameter int NUM_REQ    = NUM_MOVERS,
    parameter int DATA_WIDTH = MAZE_COLS,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_ROWS   = MAZE_ROWS,
    parameter int COL_W      = $clog2(DATA_WIDTH)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*COL_W-1:0]      req_x,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_y,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [ADDR_WIDTH-1:0]         rom_addr,
    input  logic [DATA_WIDTH-1:0]         rom_data,
    output logic [NUM_REQ-1:0]            resp_valid,
    output logic                          resp_blocked
);

    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [ADDR_WIDTH:0] ROW_LIMIT = (ADDR_WIDTH+1)'(NUM_ROWS);

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    logic [ID_W-1:0]       ptr;
    logic [ID_W-1:0]       ptr_next;
    logic [NUM_REQ-1:0]    gnt;
    logic [ID_W-1:0]       gnt_id;
    logic [COL_W-1:0]      sel_x;
    logic [ADDR_WIDTH-1:0] sel_y;
    logic                  accept;
    logic                  y_oob;
    logic                  x_oob;
    logic                  lookup_oob;

    rr_arbiter #(
        .N     (NUM_REQ),
        .PTR_W (ID_W)
    ) u_arb (
        .req (req_valid),
        .ptr (ptr),
        .gnt (gnt)
    );

    // The grant only ever selects a valid requester, so any ready bit is an
    // accept. Masking with reset keeps requests raised during reset out.
    assign req_ready = reset ? '0 : gnt;
    assign accept    = |req_ready;

    // Encode the winner and steer its coordinates onto the shared path.
    // NOTE: every variable assigned here gets a default first; otherwise the
    // no-grant case would leave them unassigned and infer latches.
    always_comb begin
        gnt_id = '0;
        sel_x  = '0;
        sel_y  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                gnt_id = ID_W'(i);
                sel_x  = req_x[i*COL_W +: COL_W];
                sel_y  = req_y[i*ADDR_WIDTH +: ADDR_WIDTH];
            end
        end
    end

    assign ptr_next = (gnt_id == ID_W'(NUM_REQ-1)) ? '0 : gnt_id + ID_W'(1);

    // Rows past the populated maze read as walls.
    assign y_oob = ({1'b0, sel_y} >= ROW_LIMIT);

    // An x beyond the ROM row can only exist when COL_W is wider than
    // needed; otherwise every x encoding is a real column.
    generate
        if ((2 ** COL_W) > DATA_WIDTH) begin : g_wide_x
            localparam logic [COL_W:0] COL_LIMIT = (COL_W+1)'(DATA_WIDTH);
            assign x_oob = ({1'b0, sel_x} >= COL_LIMIT);
        end else begin : g_exact_x
            assign x_oob = 1'b0;
        end
    endgenerate

    assign lookup_oob = y_oob | x_oob;

    // ------------------------------------------------------------------
    // Pipeline control (reset) : ptr, valids, ROM address
    // ------------------------------------------------------------------
    logic s1_valid;
    logic s2_valid;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr      <= '0;
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            rom_addr <= '0;
        end else begin
            s1_valid <= accept;
            s2_valid <= s1_valid;
            if (accept) begin
                ptr      <= ptr_next;
                // Off-maze lookups park the ROM on row 0; the answer is
                // forced to blocked downstream regardless of the data.
                rom_addr <= lookup_oob ? '0 : sel_y;
            end
        end
    end

    // ------------------------------------------------------------------
    // Pipeline payload (no reset)
    // ------------------------------------------------------------------
    logic [ID_W-1:0]  s1_id;
    logic [COL_W-1:0] s1_col;
    logic             s1_oob;
    logic [ID_W-1:0]  s2_id;
    logic [COL_W-1:0] s2_col;
    logic             s2_oob;

    // NOTE: payload registers are left unreset; they are only observed when
    // the matching valid bit is set, and that bit is reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            s1_id  <= gnt_id;
            s1_col <= sel_x;
            s1_oob <= lookup_oob;
        end
        s2_id  <= s1_id;
        s2_col <= s1_col;
        s2_oob <= s1_oob;
    end

    // ------------------------------------------------------------------
    // Response: rom_data lines up with stage 2
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] row_shifted;

    assign row_shifted = rom_data << s2_col;

    always_comb begin
        resp_valid = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            resp_valid[i] = s2_valid && (s2_id == ID_W'(i));
        end
    end

    assign resp_blocked = s2_valid & (s2_oob | row_shifted[DATA_WIDTH-1]);

endmodule

// File: tb/tb_maze_rom_arbiter.sv
// ----------------------------------------------------------------------------
// tb_maze_rom_arbiter
// Directed bench for maze_rom_arbiter. The stimulus process drives lookups,
// checks grants and ROM addresses, and queues the hand-computed answer for
// every accepted lookup; a monitor pops and compares on each response strobe.
// ----------------------------------------------------------------------------
module tb_maze_rom_arbiter;

    localparam int NR = 5;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int CW = 5;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [NR-1:0]    req_valid = '0;
    logic [NR*CW-1:0] req_x = '0;
    logic [NR*AW-1:0] req_y = '0;
    logic [NR-1:0]    req_ready;
    logic [AW-1:0]    rom_addr;
    logic [DW-1:0]    rom_data;
    logic [NR-1:0]    resp_valid;
    logic             resp_blocked;

    maze_rom_arbiter #(
        .NUM_REQ    (NR),
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .NUM_ROWS   (24),
        .COL_W      (CW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_x        (req_x),
        .req_y        (req_y),
        .req_ready    (req_ready),
        .rom_addr     (rom_addr),
        .rom_data     (rom_data),
        .resp_valid   (resp_valid),
        .resp_blocked (resp_blocked)
    );

    always #5 clk = ~clk;

    // Registered-output ROM model.
    logic [DW-1:0] rom_mem [0:31];
    always @(posedge clk) rom_data <= rom_mem[rom_addr];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        int            due;
        logic [NR-1:0] id;
        logic          blk;
    } exp_t;

    exp_t q[$];

    // Per-requester coordinates and their hand-computed answers.
    int   tx [NR];
    int   ty [NR];
    logic tb_blk [NR];

    task automatic set_req(input int i, input int x, input int y, input logic blk);
        tx[i]     = x;
        ty[i]     = y;
        tb_blk[i] = blk;
    endtask

    // One cycle of stimulus: drive, then check the grant (and optionally the
    // ROM address left by the previous accept) away from the clock edge.
    task automatic step(input logic [NR-1:0] v, input logic [NR-1:0] exp_ready,
                        input bit push, input bit chk_addr, input int exp_addr,
                        input string tag);
        @(posedge clk);
        #1;
        req_valid = v;
        for (int i = 0; i < NR; i++) begin
            req_x[i*CW +: CW] = CW'(tx[i]);
            req_y[i*AW +: AW] = AW'(ty[i]);
        end
        @(negedge clk);
        check({tag, "_ready"}, 32'(req_ready), 32'(exp_ready));
        if (chk_addr) check({tag, "_addr"}, 32'(rom_addr), exp_addr);
        if (push) begin
            for (int i = 0; i < NR; i++) begin
                if (exp_ready[i]) q.push_back('{due: cyc + 2, id: exp_ready, blk: tb_blk[i]});
            end
        end
    endtask

    task automatic do_reset(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            reset     = 1'b1;
            req_valid = '1;
            @(negedge clk);
            check("rst_ready", 32'(req_ready), 0);
            check("rst_resp_valid", 32'(resp_valid), 0);
            check("rst_resp_blocked", 32'(resp_blocked), 0);
        end
        @(posedge clk);
        #1;
        reset     = 1'b0;
        req_valid = '0;
        @(negedge clk);
        check("post_rst_addr", 32'(rom_addr), 0);
        check("post_rst_resp_valid", 32'(resp_valid), 0);
    endtask

    // Response monitor.
    always @(negedge clk) begin
        exp_t e;
        if (resp_valid != '0) begin
            if (q.size() == 0) begin
                check("resp_unexpected", 32'(resp_valid), 0);
            end else begin
                e = q.pop_front();
                check("resp_id", 32'(resp_valid), 32'(e.id));
                check("resp_blocked", 32'(resp_blocked), 32'(e.blk));
                check("resp_cycle", cyc, e.due);
            end
        end else if (q.size() != 0 && q[0].due <= cyc) begin
            e = q.pop_front();
            check("resp_missing", 32'(resp_valid), 32'(e.id));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        // Unused rows read as walls. Row 0 is all walkable so an off-maze
        // answer can only be blocked through the out-of-range path.
        for (int r = 0; r < 32; r++) rom_mem[r] = 32'hFFFF_FFFF;
        rom_mem[0]  = 32'h0000_0000;
        rom_mem[4]  = 32'h8001_0001;                          // cols 0,15,31 walls
        rom_mem[12] = 32'b11111001001010000001010010011111;   // tunnel row
        for (int i = 0; i < NR; i++) set_req(i, 0, 0, 1'b0);

        do_reset(2);

        // Single lookups by Pac-Man on row 4.
        set_req(0, 6, 4, 1'b0);
        step(5'b00001, 5'b00001, 1, 0, 0, "pac_6_4");
        step(5'b00000, 5'b00000, 0, 1, 4, "pac_idle");
        set_req(0, 15, 4, 1'b1);
        step(5'b00001, 5'b00001, 1, 0, 0, "pac_15_4");
        set_req(0, 0, 4, 1'b1);
        step(5'b00001, 5'b00001, 1, 1, 4, "pac_0_4");
        step(5'b00000, 5'b00000, 0, 1, 4, "pac_idle2");

        // Off-maze lookup by requester 2, leaves ptr = 3.
        set_req(2, 7, 30, 1'b1);
        step(5'b00100, 5'b00100, 1, 0, 0, "oob");
        step(5'b00000, 5'b00000, 0, 1, 0, "oob_addr");

        // Sparse contention behind ptr = 3: wrap to 0, then 1.
        set_req(0, 6, 4, 1'b0);
        set_req(1, 15, 4, 1'b1);
        step(5'b00011, 5'b00001, 1, 0, 0, "sparse_a");
        step(5'b00011, 5'b00010, 1, 1, 4, "sparse_b");
        step(5'b00000, 5'b00000, 0, 1, 4, "sparse_idle");

        // Tunnel row.
        set_req(0, 5, 12, 1'b0);
        step(5'b00001, 5'b00001, 1, 0, 0, "tunnel_5");
        set_req(0, 4, 12, 1'b1);
        step(5'b00001, 5'b00001, 1, 1, 12, "tunnel_4");
        step(5'b00000, 5'b00000, 0, 1, 12, "tunnel_idle");
        step(5'b00000, 5'b00000, 0, 0, 0, "drain");

        // Fairness: everyone requesting continuously from reset.
        do_reset(2);
        set_req(0, 6, 4, 1'b0);
        set_req(1, 15, 4, 1'b1);
        set_req(2, 7, 30, 1'b1);
        set_req(3, 5, 12, 1'b0);
        set_req(4, 4, 12, 1'b1);
        for (int k = 0; k < 10; k++) begin
            step(5'b11111, 5'(1 << (k % NR)), 1, 0, 0, "fair");
        end
        step(5'b00000, 5'b00000, 0, 0, 0, "drain");
        step(5'b00000, 5'b00000, 0, 0, 0, "drain");

        // Reset while a lookup is in flight: it must vanish.
        step(5'b00001, 5'b00001, 0, 0, 0, "mid_acc");
        @(posedge clk);
        #1;
        reset     = 1'b1;
        req_valid = '0;
        @(negedge clk);
        check("mid_rst_resp1", 32'(resp_valid), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("mid_rst_resp2", 32'(resp_valid), 0);
        check("mid_rst_addr", 32'(rom_addr), 0);
        // ptr was 1 before reset; a reset ptr grants requester 0 first.
        step(5'b11111, 5'b00001, 1, 0, 0, "mid_post");
        check("mid_rst_resp3", 32'(resp_valid), 0);
        step(5'b00000, 5'b00000, 0, 1, 4, "mid_post_addr");
        step(5'b00000, 5'b00000, 0, 0, 0, "drain");
        step(5'b00000, 5'b00000, 0, 0, 0, "drain");

        repeat (3) @(negedge clk);
        check("queue_empty", 32'(q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
